iob_axis_packer: RTL and testbench

//  Width-up AXI-Stream packer that sits directly upstream of the DMA AXIS input mux.

---
 rtl/iob_axis_pkg.sv | 30 +++
 rtl/iob_counter.sv | 30 +++
 rtl/iob_axis_packer.sv | 140 ++++++++++++++
 tb/tb_iob_axis_packer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_axis_pkg.sv
// Shared definitions for the AXIS width-up packer: lane geometry and keep-mask helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package iob_axis_pkg;

   // Geometry of the default configuration (8-bit peripheral into a 32-bit DMA word).
   localparam int unsigned DEF_IN_W  = 8;
   localparam int unsigned DEF_OUT_W = 32;
   localparam int unsigned RATIO     = DEF_OUT_W / DEF_IN_W;
   localparam int unsigned LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

   // Widest lane count the keep-mask helper can describe.
   localparam int unsigned MAX_RATIO = 64;

   // Lane-index width for an arbitrary lane count; never narrower than one bit.
   function automatic int unsigned lane_w_of(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   // Thermometer mask with lanes 0..lane_idx set; callers truncate to their lane count.
   function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned lane_idx);
      logic [MAX_RATIO-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_RATIO; i++) begin
         if (i <= lane_idx) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/iob_counter.sv
// Free-running up-counter with enable, synchronous clear and clock enable; wraps at 2^DATA_W.
// Latency: data_o reflects an enabled cycle one clock later.
// Backpressure: none; counts every cycle where cke_i and en_i are both high.
// Ports: clk_i/cke_i/arst_n_i/rst_i control, en_i increment request, data_o count value.
module iob_counter #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              arst_n_i,
   input  logic              rst_i,
   input  logic              en_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q <= '0;
      end else if (rst_i) begin
         cnt_q <= '0;
      end else if (cke_i && en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign data_o = cnt_q;

endmodule

// File: rtl/iob_axis_packer.sv
// Width-up AXIS packer: gathers IN_W beats little-endian into OUT_W words, flushing partial words on tlast.
// Latency: word is valid the cycle after its completing beat; sustains one input beat per cycle.
// Backpressure: in_tready_o = cke_i & (output register empty or being drained); output holds while stalled.
// Ports: clk_i/cke_i/arst_n_i/rst_i control; in_t* narrow AXIS slave; out_t* wide AXIS master
//        (out_tkeep_o one bit per lane); word_cnt_o counts output handshakes.
module iob_axis_packer #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32,
   parameter int CNT_W = 32
) (
   input  logic                   clk_i,
   input  logic                   cke_i,
   input  logic                   arst_n_i,
   input  logic                   rst_i,
   input  logic [IN_W-1:0]        in_tdata_i,
   input  logic                   in_tvalid_i,
   input  logic                   in_tlast_i,
   output logic                   in_tready_o,
   output logic [OUT_W-1:0]       out_tdata_o,
   output logic [OUT_W/IN_W-1:0]  out_tkeep_o,
   output logic                   out_tlast_o,
   output logic                   out_tvalid_o,
   input  logic                   out_tready_i,
   output logic [CNT_W-1:0]       word_cnt_o
);

   import iob_axis_pkg::*;

   localparam int unsigned LANES = OUT_W / IN_W;
   localparam int unsigned LSB_W = lane_w_of(LANES);

   if (OUT_W % IN_W != 0) begin : g_width_check
      $error("iob_axis_packer: OUT_W must be a multiple of IN_W");
   end

   logic [OUT_W-1:0] acc_q, acc_d;
   logic [LANES-1:0] keep_acc_q, keep_acc_d;
   logic [LSB_W-1:0] lane_q, lane_d;
   logic [OUT_W-1:0] out_tdata_q, out_tdata_d;
   logic [LANES-1:0] out_tkeep_q, out_tkeep_d;
   logic             out_tlast_q, out_tlast_d;
   logic             out_tvalid_q, out_tvalid_d;

   logic             in_hs, out_hs, complete;
   logic [LANES-1:0] lane_mask, merged_keep;
   logic [OUT_W-1:0] merged_word;

   assign in_tready_o = cke_i & (~out_tvalid_q | out_tready_i);
   assign in_hs       = in_tvalid_i & in_tready_o;
   assign out_hs      = cke_i & out_tvalid_q & out_tready_i;
   assign complete    = (lane_q == LSB_W'(LANES - 1)) | in_tlast_i;

   // Merge the incoming beat into the partial word; lanes above the write lane are zeroed.
   always_comb begin
      lane_mask   = LANES'(keep_mask(32'(lane_q)));
      merged_keep = keep_acc_q | (LANES'(1) << lane_q);
      merged_word = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (LSB_W'(l) == lane_q) begin
            merged_word[l*IN_W +: IN_W] = in_tdata_i;
         end else if (lane_mask[l]) begin
            merged_word[l*IN_W +: IN_W] = acc_q[l*IN_W +: IN_W];
         end
      end
   end

   always_comb begin
      acc_d        = acc_q;
      keep_acc_d   = keep_acc_q;
      lane_d       = lane_q;
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tlast_d  = out_tlast_q;
      out_tvalid_d = out_tvalid_q;

      // A drained word empties the register unless a completing beat refills it below.
      if (out_hs) out_tvalid_d = 1'b0;

      if (in_hs) begin
         if (complete) begin
            out_tdata_d  = merged_word;
            out_tkeep_d  = merged_keep;
            out_tlast_d  = in_tlast_i;
            out_tvalid_d = 1'b1;
            acc_d        = '0;
            keep_acc_d   = '0;
            lane_d       = '0;
         end else begin
            acc_d      = merged_word;
            keep_acc_d = merged_keep;
            lane_d     = lane_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         acc_q        <= '0;
         keep_acc_q   <= '0;
         lane_q       <= '0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
      end else if (rst_i) begin
         acc_q        <= '0;
         keep_acc_q   <= '0;
         lane_q       <= '0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
      end else if (cke_i) begin
         acc_q        <= acc_d;
         keep_acc_q   <= keep_acc_d;
         lane_q       <= lane_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tlast_q  <= out_tlast_d;
         out_tvalid_q <= out_tvalid_d;
      end
   end

   assign out_tdata_o  = out_tdata_q;
   assign out_tkeep_o  = out_tkeep_q;
   assign out_tlast_o  = out_tlast_q;
   assign out_tvalid_o = out_tvalid_q;

   iob_counter #(
      .DATA_W (CNT_W)
   ) u_word_cnt (
      .clk_i    (clk_i),
      .cke_i    (cke_i),
      .arst_n_i (arst_n_i),
      .rst_i    (rst_i),
      .en_i     (out_hs),
      .data_o   (word_cnt_o)
   );

endmodule

// File: tb/tb_iob_axis_packer.sv
// Directed bench for iob_axis_packer with IN_W=8, OUT_W=32.
// Latency: n/a.
// Backpressure: out_tready driven per scenario; a monitor logs every output handshake.
module tb_iob_axis_packer;

   logic        clk;
   logic        cke;
   logic        arst_n;
   logic        rst;
   logic [7:0]  in_tdata;
   logic        in_tvalid;
   logic        in_tlast;
   logic        in_tready;
   logic [31:0] out_tdata;
   logic [3:0]  out_tkeep;
   logic        out_tlast;
   logic        out_tvalid;
   logic        out_tready;
   logic [31:0] word_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] q_dat[$];
   logic [3:0]  q_keep[$];
   logic        q_last[$];
   int          q_cyc[$];

   iob_axis_packer #(.IN_W(8), .OUT_W(32), .CNT_W(32)) dut (
      .clk_i        (clk),
      .cke_i        (cke),
      .arst_n_i     (arst_n),
      .rst_i        (rst),
      .in_tdata_i   (in_tdata),
      .in_tvalid_i  (in_tvalid),
      .in_tlast_i   (in_tlast),
      .in_tready_o  (in_tready),
      .out_tdata_o  (out_tdata),
      .out_tkeep_o  (out_tkeep),
      .out_tlast_o  (out_tlast),
      .out_tvalid_o (out_tvalid),
      .out_tready_i (out_tready),
      .word_cnt_o   (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: records every accepted word and the cycle it was taken.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (arst_n && !rst && cke && out_tvalid && out_tready) begin
         q_dat.push_back(out_tdata);
         q_keep.push_back(out_tkeep);
         q_last.push_back(out_tlast);
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Presents one beat and returns at posedge+1 of the edge that accepted it.
   task automatic send_beat(input logic [7:0] d, input logic l);
      logic rdy;
      int   n;
      in_tdata  = d;
      in_tlast  = l;
      in_tvalid = 1'b1;
      n = 0;
      forever begin
         #2;
         rdy = in_tready;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 50) begin
            total++; bad++;
            $display("FAIL send_timeout beat=%h never accepted", d);
            break;
         end
      end
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
   endtask

   task automatic do_reset();
      in_tvalid  = 1'b0;
      in_tlast   = 1'b0;
      in_tdata   = 8'h00;
      cke        = 1'b1;
      out_tready = 1'b1;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_dat.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      in_tvalid = 1'b1;
      #12;
      total++; if (out_tvalid !== 1'b0)   begin bad++; $display("FAIL rst_tvalid got=%b exp=0", out_tvalid); end
      total++; if (out_tdata !== 32'h0)   begin bad++; $display("FAIL rst_tdata got=%h exp=0", out_tdata); end
      total++; if (out_tkeep !== 4'h0)    begin bad++; $display("FAIL rst_tkeep got=%b exp=0000", out_tkeep); end
      total++; if (out_tlast !== 1'b0)    begin bad++; $display("FAIL rst_tlast got=%b exp=0", out_tlast); end
      total++; if (word_cnt !== 32'd0)    begin bad++; $display("FAIL rst_cnt got=%0d exp=0", word_cnt); end
      total++; if (in_tready !== 1'b1)    begin bad++; $display("FAIL rst_tready got=%b exp=1", in_tready); end
      in_tvalid = 1'b0;
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   task automatic test_full_word();
      do_reset();
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h33, 1'b0);
      send_beat(8'h44, 1'b0);
      total++; if (out_tvalid !== 1'b1)       begin bad++; $display("FAIL full_tvalid got=%b exp=1", out_tvalid); end
      total++; if (out_tdata !== 32'h44332211) begin bad++; $display("FAIL full_tdata got=%h exp=44332211", out_tdata); end
      total++; if (out_tkeep !== 4'b1111)     begin bad++; $display("FAIL full_tkeep got=%b exp=1111", out_tkeep); end
      total++; if (out_tlast !== 1'b0)        begin bad++; $display("FAIL full_tlast got=%b exp=0", out_tlast); end
      @(posedge clk);
      #1;
      total++; if (word_cnt !== 32'd1)        begin bad++; $display("FAIL full_cnt got=%0d exp=1", word_cnt); end
      total++; if (out_tvalid !== 1'b0)       begin bad++; $display("FAIL full_drain got=%b exp=0", out_tvalid); end
   endtask

   task automatic test_tlast();
      do_reset();
      send_beat(8'hAA, 1'b0);
      send_beat(8'hBB, 1'b1);
      total++; if (out_tdata !== 32'h0000BBAA) begin bad++; $display("FAIL tlast_tdata got=%h exp=0000bbaa", out_tdata); end
      total++; if (out_tkeep !== 4'b0011)      begin bad++; $display("FAIL tlast_tkeep got=%b exp=0011", out_tkeep); end
      total++; if (out_tlast !== 1'b1)         begin bad++; $display("FAIL tlast_tlast got=%b exp=1", out_tlast); end
      // Next packet is a single beat: lands in lane 0 while the previous word drains.
      send_beat(8'hCC, 1'b1);
      total++; if (out_tvalid !== 1'b1)        begin bad++; $display("FAIL lane0_tvalid got=%b exp=1", out_tvalid); end
      total++; if (out_tdata !== 32'h000000CC) begin bad++; $display("FAIL lane0_tdata got=%h exp=000000cc", out_tdata); end
      total++; if (out_tkeep !== 4'b0001)      begin bad++; $display("FAIL lane0_tkeep got=%b exp=0001", out_tkeep); end
      total++; if (word_cnt !== 32'd1)         begin bad++; $display("FAIL lane0_cnt got=%0d exp=1", word_cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
      fork
         begin
            for (int i = 1; i <= 8; i++) send_beat(8'((i << 4) | i), 1'b0);
         end
         begin
            int n;
            n = 0;
            while (out_tvalid !== 1'b1 && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            out_tready = 1'b0;
            #1;
            total++; if (in_tready !== 1'b0) begin bad++; $display("FAIL bp_tready got=%b exp=0", in_tready); end
            repeat (3) begin
               @(posedge clk);
               #1;
            end
            total++; if (out_tdata !== 32'h44332211) begin bad++; $display("FAIL bp_hold got=%h exp=44332211", out_tdata); end
            total++; if (out_tvalid !== 1'b1)        begin bad++; $display("FAIL bp_hold_vld got=%b exp=1", out_tvalid); end
            out_tready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      total++; if (q_dat.size() !== 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", q_dat.size()); end
      if (q_dat.size() >= 2) begin
         total++; if (q_dat[0] !== 32'h44332211) begin bad++; $display("FAIL bp_word0 got=%h exp=44332211", q_dat[0]); end
         total++; if (q_dat[1] !== 32'h88776655) begin bad++; $display("FAIL bp_word1 got=%h exp=88776655", q_dat[1]); end
      end
   endtask

   task automatic test_back_to_back();
      int start;
      logic [31:0] e;
      do_reset();
      total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL b2b_clear got=%0d exp=0", word_cnt); end
      start = cyc;
      for (int i = 0; i < 64; i++) send_beat(8'(i), 1'b0);
      total++; if (cyc - start !== 64) begin bad++; $display("FAIL b2b_cycles got=%0d exp=64", cyc - start); end
      repeat (2) @(posedge clk);
      #1;
      total++; if (q_dat.size() !== 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", q_dat.size()); end
      for (int j = 0; j < q_dat.size(); j++) begin
         for (int k = 0; k < 4; k++) e[8*k +: 8] = 8'(4*j + k);
         total++; if (q_dat[j] !== e) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", j, q_dat[j], e); end
         if (j > 0) begin
            total++; if (q_cyc[j] - q_cyc[j-1] !== 4) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=4", j, q_cyc[j] - q_cyc[j-1]); end
         end
      end
      total++; if (word_cnt !== 32'd16) begin bad++; $display("FAIL b2b_cnt got=%0d exp=16", word_cnt); end
      // Single-beat packets: every beat completes while the previous word drains.
      q_dat.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
      start = cyc;
      for (int i = 0; i < 4; i++) send_beat(8'hF0 + 8'(i), 1'b1);
      total++; if (cyc - start !== 4) begin bad++; $display("FAIL b2b1_cycles got=%0d exp=4", cyc - start); end
      repeat (2) @(posedge clk);
      #1;
      total++; if (q_dat.size() !== 4) begin bad++; $display("FAIL b2b1_count got=%0d exp=4", q_dat.size()); end
      for (int j = 0; j < q_dat.size(); j++) begin
         e = {24'h0, 8'hF0 + 8'(j)};
         total++; if (q_dat[j] !== e || q_keep[j] !== 4'b0001 || q_last[j] !== 1'b1) begin
            bad++; $display("FAIL b2b1_word%0d got=%h/%b/%b exp=%h/0001/1", j, q_dat[j], q_keep[j], q_last[j], e);
         end
         if (j > 0) begin
            total++; if (q_cyc[j] - q_cyc[j-1] !== 1) begin bad++; $display("FAIL b2b1_gap%0d got=%0d exp=1", j, q_cyc[j] - q_cyc[j-1]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_beat(8'hA1, 1'b0);
      send_beat(8'hA2, 1'b0);
      arst_n = 1'b0;
      #2;
      total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_tvalid got=%b exp=0", out_tvalid); end
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      send_beat(8'h03, 1'b0);
      send_beat(8'h04, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      total++; if (q_dat.size() !== 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", q_dat.size()); end
      if (q_dat.size() >= 1) begin
         total++; if (q_dat[0] !== 32'h04030201) begin bad++; $display("FAIL rmid_word got=%h exp=04030201", q_dat[0]); end
         total++; if (q_keep[0] !== 4'b1111)     begin bad++; $display("FAIL rmid_keep got=%b exp=1111", q_keep[0]); end
      end
      total++; if (word_cnt !== 32'd1) begin bad++; $display("FAIL rmid_cnt got=%0d exp=1", word_cnt); end
   endtask

   task automatic test_cke();
      do_reset();
      out_tready = 1'b0;
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h33, 1'b0);
      send_beat(8'h44, 1'b0);
      // Pending word must survive a frozen cycle even though the sink is ready.
      cke = 1'b0;
      out_tready = 1'b1;
      in_tvalid = 1'b1;
      in_tdata = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         #2;
         total++; if (in_tready !== 1'b0 || out_tvalid !== 1'b1 || word_cnt !== 32'd0 || out_tdata !== 32'h44332211) begin
            bad++; $display("FAIL cke_hold%0d got=rdy%b vld%b cnt%0d dat%h exp=rdy0 vld1 cnt0 dat44332211", i, in_tready, out_tvalid, word_cnt, out_tdata);
         end
         @(posedge clk);
         #1;
      end
      in_tvalid = 1'b0;
      cke = 1'b1;
      send_beat(8'h55, 1'b0);
      send_beat(8'h66, 1'b0);
      cke = 1'b0;
      in_tvalid = 1'b1;
      in_tdata = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         #2;
         total++; if (in_tready !== 1'b0 || out_tvalid !== 1'b0 || word_cnt !== 32'd1) begin
            bad++; $display("FAIL cke_mid%0d got=rdy%b vld%b cnt%0d exp=rdy0 vld0 cnt1", i, in_tready, out_tvalid, word_cnt);
         end
         @(posedge clk);
         #1;
      end
      in_tvalid = 1'b0;
      cke = 1'b1;
      send_beat(8'h77, 1'b0);
      send_beat(8'h88, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      total++; if (q_dat.size() !== 2) begin bad++; $display("FAIL cke_count got=%0d exp=2", q_dat.size()); end
      if (q_dat.size() >= 2) begin
         total++; if (q_dat[0] !== 32'h44332211) begin bad++; $display("FAIL cke_word0 got=%h exp=44332211", q_dat[0]); end
         total++; if (q_dat[1] !== 32'h88776655) begin bad++; $display("FAIL cke_word1 got=%h exp=88776655", q_dat[1]); end
      end
      total++; if (word_cnt !== 32'd2) begin bad++; $display("FAIL cke_cnt got=%0d exp=2", word_cnt); end
   endtask

   initial begin
      cke        = 1'b1;
      arst_n     = 1'b0;
      rst        = 1'b0;
      in_tdata   = 8'h00;
      in_tvalid  = 1'b0;
      in_tlast   = 1'b0;
      out_tready = 1'b1;
      test_reset();
      test_full_word();
      test_tlast();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_cke();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
